// File: rtl/p_multicycle_control.sv
// Multicycle MIPS control sequencer: steps fetch/decode/execute/memory/writeback
// over one shared memory port, stalling on P_mem_ready.
module p_multicycle_control (
  input  logic       P_clk,
  input  logic       P_rst_n,
  input  logic [5:0] P_opcode,
  input  logic       P_zero,
  input  logic       P_mem_ready,
  output logic       P_PCWrite,
  output logic       P_PCWriteCond,
  output logic       P_IorD,
  output logic       P_MemRead,
  output logic       P_MemWrite,
  output logic       P_IRWrite,
  output logic       P_MemtoReg,
  output logic       P_RegDst,
  output logic       P_RegWrite,
  output logic       P_ALUSrcA,
  output logic [1:0] P_ALUSrcB,
  output logic [1:0] P_ALUOp,
  output logic [1:0] P_PCSource,
  output logic [3:0] P_state,
  output logic       P_illegal
);

  // state  | meaning
  // IDLE   | post-reset, all outputs quiet
  // FETCH  | read instruction at PC, PC += 4 when memory is ready
  // DECODE | latch opcode, precompute branch target
  // MEMADR | lw/sw effective address
  // MEMRD  | data read (waits on ready)
  // MEMWB  | MDR -> rt
  // MEMWR  | data write (waits on ready)
  // EXEC   | R-type ALU operation
  // ALUWB  | ALUOut -> rd
  // BRANCH | beq compare, PC <= target if zero
  // IMMEX  | addi/ori ALU operation
  // IMMWB  | ALUOut -> rt
  // JUMP   | PC <= jump target
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;

  // Zero only qualifies PCWriteCond in the datapath; the sequence never looks at it.
  logic unused_zero;
  assign unused_zero = P_zero;

  always_ff @(posedge P_clk) begin
    if (!P_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    P_PCWrite     = 1'b0;
    P_PCWriteCond = 1'b0;
    P_IorD        = 1'b0;
    P_MemRead     = 1'b0;
    P_MemWrite    = 1'b0;
    P_IRWrite     = 1'b0;
    P_MemtoReg    = 1'b0;
    P_RegDst      = 1'b0;
    P_RegWrite    = 1'b0;
    P_ALUSrcA     = 1'b0;
    P_ALUSrcB     = 2'b00;
    P_ALUOp       = 2'b00;
    P_PCSource    = 2'b00;
    P_illegal     = 1'b0;
    P_state       = state_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        P_MemRead = 1'b1;
        P_ALUSrcB = 2'b01;
        P_IRWrite = P_mem_ready;
        P_PCWrite = P_mem_ready;
        if (P_mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        P_ALUSrcB = 2'b11;
        op_d      = P_opcode;
        case (P_opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI,
          OP_ORI:       state_d = S_IMMEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            P_illegal = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        P_ALUSrcA = 1'b1;
        P_ALUSrcB = 2'b10;
        state_d   = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        P_IorD    = 1'b1;
        P_MemRead = 1'b1;
        if (P_mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        P_RegWrite = 1'b1;
        P_MemtoReg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        P_IorD     = 1'b1;
        P_MemWrite = 1'b1;
        if (P_mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        P_ALUSrcA = 1'b1;
        P_ALUOp   = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        P_RegWrite = 1'b1;
        P_RegDst   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        P_ALUSrcA     = 1'b1;
        P_ALUOp       = 2'b01;
        P_PCWriteCond = 1'b1;
        P_PCSource    = 2'b01;
        state_d       = S_FETCH;
      end
      S_IMMEX: begin
        P_ALUSrcA = 1'b1;
        P_ALUSrcB = 2'b10;
        P_ALUOp   = (op_q == OP_ORI) ? 2'b11 : 2'b00;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        P_RegWrite = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        P_PCWrite  = 1'b1;
        P_PCSource = 2'b10;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_p_multicycle_control.sv
// Directed bench for p_multicycle_control: per-cycle compare against a
// rule-level expected state/output sequence, plus literal sequence pins.
module tb_p_multicycle_control;

  logic       P_clk = 1'b0;
  logic       P_rst_n = 1'b0;
  logic [5:0] P_opcode = '0;
  logic       P_zero = 1'b0;
  logic       P_mem_ready = 1'b0;
  logic       P_PCWrite, P_PCWriteCond, P_IorD, P_MemRead, P_MemWrite, P_IRWrite;
  logic       P_MemtoReg, P_RegDst, P_RegWrite, P_ALUSrcA, P_illegal;
  logic [1:0] P_ALUSrcB, P_ALUOp, P_PCSource;
  logic [3:0] P_state;

  p_multicycle_control dut (
    .P_clk(P_clk), .P_rst_n(P_rst_n), .P_opcode(P_opcode), .P_zero(P_zero),
    .P_mem_ready(P_mem_ready), .P_PCWrite(P_PCWrite), .P_PCWriteCond(P_PCWriteCond),
    .P_IorD(P_IorD), .P_MemRead(P_MemRead), .P_MemWrite(P_MemWrite),
    .P_IRWrite(P_IRWrite), .P_MemtoReg(P_MemtoReg), .P_RegDst(P_RegDst),
    .P_RegWrite(P_RegWrite), .P_ALUSrcA(P_ALUSrcA), .P_ALUSrcB(P_ALUSrcB),
    .P_ALUOp(P_ALUOp), .P_PCSource(P_PCSource), .P_state(P_state), .P_illegal(P_illegal)
  );

  always #5 P_clk = ~P_clk;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010, BAD = 6'b111111;

  int vectors = 0;
  int miscompares = 0;
  int tr_st[$];
  int tr_ao[$];

  logic [16:0] dut_o;
  assign dut_o = {P_PCWrite, P_PCWriteCond, P_IorD, P_MemRead, P_MemWrite, P_IRWrite,
                  P_MemtoReg, P_RegDst, P_RegWrite, P_ALUSrcA, P_ALUSrcB, P_ALUOp,
                  P_PCSource, P_illegal};

  function automatic bit legal(logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, ADDI, ORI, JMP};
  endfunction

  // Expected outputs for a state, from the per-state output list.
  function automatic logic [16:0] expo(int st, logic [5:0] lop, logic rdy, logic [5:0] dop);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (st)
      1:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      2:  begin sb = 2'b11; ill = !legal(dop); end
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin iord = 1; mr = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin iord = 1; mw = 1; end
      7:  begin sa = 1; ao = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
      10: begin sa = 1; sb = 2'b10; ao = (lop == ORI) ? 2'b11 : 2'b00; end
      11: rw = 1;
      12: begin pcw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
  endfunction

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare at the falling edge.
  task automatic cyc(logic rstn, logic rdy, logic [5:0] dop, logic z, int exp_st, logic [5:0] lop);
    @(posedge P_clk);
    #1;
    P_rst_n = rstn; P_mem_ready = rdy; P_opcode = dop; P_zero = z;
    @(negedge P_clk);
    tr_st.push_back(int'(P_state));
    tr_ao.push_back(int'(P_ALUOp));
    chk($sformatf("state@%0t", $time), int'(P_state), exp_st);
    chk($sformatf("outputs(st%0d)@%0t", exp_st, $time), int'(dut_o), int'(expo(exp_st, lop, rdy, dop)));
  endtask

  // Builds the instruction's expected state walk from the sequencing rules, then runs it.
  task automatic run_instr(logic [5:0] op, int fst, int mst, logic z);
    int st_q[$];
    bit rdy_q[$];
    tr_st.delete();
    tr_ao.delete();
    for (int i = 0; i < fst; i++) begin st_q.push_back(1); rdy_q.push_back(0); end
    st_q.push_back(1); rdy_q.push_back(1);
    st_q.push_back(2); rdy_q.push_back(0);
    if (op == RT) begin st_q.push_back(7); st_q.push_back(8); rdy_q.push_back(0); rdy_q.push_back(0); end
    else if (op == LW) begin
      st_q.push_back(3); rdy_q.push_back(0);
      for (int i = 0; i < mst; i++) begin st_q.push_back(4); rdy_q.push_back(0); end
      st_q.push_back(4); rdy_q.push_back(1);
      st_q.push_back(5); rdy_q.push_back(0);
    end else if (op == SW) begin
      st_q.push_back(3); rdy_q.push_back(0);
      for (int i = 0; i < mst; i++) begin st_q.push_back(6); rdy_q.push_back(0); end
      st_q.push_back(6); rdy_q.push_back(1);
    end else if (op == BEQ) begin st_q.push_back(9); rdy_q.push_back(0); end
    else if (op == ADDI || op == ORI) begin st_q.push_back(10); st_q.push_back(11); rdy_q.push_back(0); rdy_q.push_back(0); end
    else if (op == JMP) begin st_q.push_back(12); rdy_q.push_back(0); end
    for (int i = 0; i < st_q.size(); i++)
      cyc(1'b1, rdy_q[i], (st_q[i] <= 2) ? op : BAD, z, st_q[i], op);
  endtask

  task automatic check_seq(string nm, input int e[$]);
    chk({nm, "_len"}, tr_st.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < tr_st.size()) chk($sformatf("%s_st%0d", nm, i), tr_st[i], e[i]);
  endtask

  function automatic int ao_at(int i);
    return (i < tr_ao.size()) ? tr_ao[i] : -1;
  endfunction

  initial begin
    cyc(1'b0, 1'b0, RT, 1'b0, 0, RT);
    cyc(1'b1, 1'b0, RT, 1'b0, 0, RT);

    // lw interrupted by reset while waiting in MEMRD
    cyc(1'b1, 1'b1, LW, 1'b0, 1, LW);
    cyc(1'b1, 1'b0, LW, 1'b0, 2, LW);
    cyc(1'b1, 1'b0, BAD, 1'b0, 3, LW);
    cyc(1'b0, 1'b0, BAD, 1'b0, 4, LW);
    cyc(1'b1, 1'b0, BAD, 1'b0, 0, LW);

    run_instr(RT, 1, 0, 1'b0);
    check_seq("rtype_after_reset", '{1, 1, 2, 7, 8});
    run_instr(RT, 0, 0, 1'b0);
    check_seq("rtype", '{1, 2, 7, 8});
    chk("rtype_exec_aluop", ao_at(2), 2);

    run_instr(LW, 0, 2, 1'b0);
    check_seq("lw_stall2", '{1, 2, 3, 4, 4, 4, 5});
    run_instr(LW, 0, 0, 1'b1);
    check_seq("lw", '{1, 2, 3, 4, 5});
    run_instr(SW, 0, 1, 1'b0);
    check_seq("sw_stall1", '{1, 2, 3, 6, 6});

    run_instr(ORI, 0, 0, 1'b0);
    chk("ori_immex_aluop", ao_at(2), 3);
    run_instr(ADDI, 0, 0, 1'b0);
    check_seq("addi", '{1, 2, 10, 11});
    chk("addi_immex_aluop", ao_at(2), 0);

    run_instr(BEQ, 0, 0, 1'b0);
    check_seq("beq_z0", '{1, 2, 9});
    chk("beq_aluop", ao_at(2), 1);
    run_instr(BEQ, 0, 0, 1'b1);
    check_seq("beq_z1", '{1, 2, 9});

    run_instr(JMP, 0, 0, 1'b0);
    check_seq("j", '{1, 2, 12});

    run_instr(BAD, 3, 0, 1'b0);
    check_seq("illegal_fstall3", '{1, 1, 1, 1, 2});
    run_instr(6'b010101, 0, 0, 1'b0);
    check_seq("illegal2", '{1, 2});

    cyc(1'b1, 1'b0, RT, 1'b0, 1, RT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
